// File: rtl/mem_boot_loader_pkg.sv
// Shared types and constants for the memory boot loader: FSM states, address shifts
// and the CPU STOP opcode that drives the halt indication.
package mem_boot_loader_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StLoadD,
        StLoadI,
        StRelease,
        StRun,
        StHalted,
        StDumpRd,
        StDumpCap,
        StDumpOut
    } state_e;

    localparam int unsigned IMEM_ADDR_SHIFT = 2;
    localparam int unsigned DMEM_ADDR_SHIFT = 3;

    localparam logic [6:0] STOP_OPCODE = 7'b1111110;

    // Byte address of a word index on a port with the given word size (log2 bytes).
    function automatic logic [63:0] word_addr(input logic [63:0] index, input int unsigned shift);
        return index << shift;
    endfunction

endpackage

// File: rtl/mem_boot_loader_if.sv
// Host link, dump stream and CPU external-port signals of the boot loader.
// The loader uses the master modport; the host/CPU side uses slave.
interface mem_boot_loader_if #(
    parameter int unsigned CNT_W = 11
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic             halt;
    logic             dump_req;
    logic [CNT_W-1:0] dump_len;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [63:0]      addr_ext;
    logic [63:0]      wdata_ext;
    logic             wen_ext;
    logic             ren_ext;
    logic [63:0]      addr_ext_2;
    logic [63:0]      wdata_ext_2;
    logic             wen_ext_2;
    logic             ren_ext_2;
    logic [63:0]      rdata_ext_2;
    logic             enable;
    logic             busy;
    logic             done;

    modport master (
        input  start, in_valid, in_data, halt, dump_req, dump_len, out_ready, rdata_ext_2,
        output in_ready, out_valid, out_data, addr_ext, wdata_ext, wen_ext, ren_ext,
               addr_ext_2, wdata_ext_2, wen_ext_2, ren_ext_2, enable, busy, done
    );

    modport slave (
        output start, in_valid, in_data, halt, dump_req, dump_len, out_ready, rdata_ext_2,
        input  in_ready, out_valid, out_data, addr_ext, wdata_ext, wen_ext, ren_ext,
               addr_ext_2, wdata_ext_2, wen_ext_2, ren_ext_2, enable, busy, done
    );

endinterface

// File: rtl/mem_boot_loader_word_counter.sv
// Word counter with clear, increment and a loadable terminal value; at_last_o flags the
// final index (count == terminal - 1) so the caller can act on the last transfer.
module word_counter #(
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_last_o
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] term_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            term_q  <= '0;
        end else begin
            if (clr_i) begin
                count_q <= '0;
            end else if (inc_i) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (load_i) begin
                term_q <= load_val_i;
            end
        end
    end

    assign count_o   = count_q;
    assign at_last_o = (count_q == term_q - CNT_W'(1));

endmodule

// File: rtl/mem_boot_loader.sv
// Boot loader: streams words into dmem then imem, releases the CPU, waits for halt and
// dumps a window of dmem back out on request.
module mem_boot_loader
    import mem_boot_loader_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned DMEM_WORDS = 1024,
    parameter int unsigned CNT_W      = 11
) (
    input logic               clk,
    input logic               rst,
    mem_boot_loader_if.master bus
);
    state_e           state_q;
    logic [63:0]      addr_ext_q;
    logic [63:0]      wdata_ext_q;
    logic             wen_ext_q;
    logic [63:0]      addr_ext_2_q;
    logic [63:0]      wdata_ext_2_q;
    logic             wen_ext_2_q;
    logic             ren_ext_2_q;
    logic [63:0]      out_data_q;
    logic             done_q;

    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_last;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;
    assign cnt_next = cnt + CNT_W'(1);

    word_counter #(
        .CNT_W(CNT_W)
    ) u_word_counter (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .load_i    (cnt_load),
        .load_val_i(cnt_load_val),
        .count_o   (cnt),
        .at_last_o (cnt_last)
    );

    // Counter control mirrors the FSM transitions below; the terminal value is reloaded
    // whenever the count restarts for a new phase.
    always_comb begin
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    cnt_clr      = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(DMEM_WORDS);
                end
            end
            StLoadD: begin
                if (in_fire) begin
                    if (cnt_last) begin
                        cnt_clr      = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(IMEM_WORDS);
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            StLoadI: cnt_inc = in_fire;
            StHalted: begin
                if (bus.dump_req && (bus.dump_len != '0)) begin
                    cnt_clr      = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = bus.dump_len;
                end
            end
            StDumpOut: cnt_inc = out_fire;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_ext_q    <= '0;
            wdata_ext_q   <= '0;
            wen_ext_q     <= 1'b0;
            addr_ext_2_q  <= '0;
            wdata_ext_2_q <= '0;
            wen_ext_2_q   <= 1'b0;
            ren_ext_2_q   <= 1'b0;
            out_data_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            wen_ext_q   <= 1'b0;
            wen_ext_2_q <= 1'b0;
            ren_ext_2_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) state_q <= StLoadD;
                end
                StLoadD: begin
                    if (in_fire) begin
                        wen_ext_2_q   <= 1'b1;
                        addr_ext_2_q  <= word_addr(64'(cnt), DMEM_ADDR_SHIFT);
                        wdata_ext_2_q <= bus.in_data;
                        if (cnt_last) state_q <= StLoadI;
                    end
                end
                StLoadI: begin
                    if (in_fire) begin
                        wen_ext_q   <= 1'b1;
                        addr_ext_q  <= word_addr(64'(cnt), IMEM_ADDR_SHIFT);
                        wdata_ext_q <= bus.in_data;
                        if (cnt_last) state_q <= StRelease;
                    end
                end
                StRelease: state_q <= StRun;
                StRun: begin
                    if (bus.halt) state_q <= StHalted;
                end
                StHalted: begin
                    if (bus.dump_req) begin
                        if (bus.dump_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q      <= StDumpRd;
                            ren_ext_2_q  <= 1'b1;
                            addr_ext_2_q <= '0;
                        end
                    end
                end
                StDumpRd: state_q <= StDumpCap;
                StDumpCap: begin
                    out_data_q <= bus.rdata_ext_2;
                    state_q    <= StDumpOut;
                end
                StDumpOut: begin
                    if (out_fire) begin
                        if (cnt_last) begin
                            done_q  <= 1'b1;
                            state_q <= StHalted;
                        end else begin
                            // Issue the next read straight away so it is live in DUMP_RD.
                            state_q      <= StDumpRd;
                            ren_ext_2_q  <= 1'b1;
                            addr_ext_2_q <= word_addr(64'(cnt_next), DMEM_ADDR_SHIFT);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == StLoadD) || (state_q == StLoadI);
    assign bus.enable      = (state_q == StRun);
    assign bus.busy        = (state_q != StIdle) && (state_q != StHalted);
    assign bus.out_valid   = (state_q == StDumpOut);
    assign bus.out_data    = out_data_q;
    assign bus.addr_ext    = addr_ext_q;
    assign bus.wdata_ext   = wdata_ext_q;
    assign bus.wen_ext     = wen_ext_q;
    assign bus.ren_ext     = 1'b0;
    assign bus.addr_ext_2  = addr_ext_2_q;
    assign bus.wdata_ext_2 = wdata_ext_2_q;
    assign bus.wen_ext_2   = wen_ext_2_q;
    assign bus.ren_ext_2   = ren_ext_2_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader with 4-word dmem/imem images and a behavioural dmem.
module tb_mem_boot_loader;
    localparam int unsigned CNT_W = 11;

    typedef struct {
        logic [63:0] data;
        logic        imem;
        logic [63:0] addr;
    } load_vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_boot_loader_if #(.CNT_W(CNT_W)) bus ();

    mem_boot_loader #(
        .IMEM_WORDS(4),
        .DMEM_WORDS(4),
        .CNT_W     (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural dmem: read data valid the cycle after ren_ext_2.
    logic [63:0] dmem [8];
    always @(posedge clk) begin
        if (bus.wen_ext_2) dmem[bus.addr_ext_2[5:3]] <= bus.wdata_ext_2;
        if (bus.ren_ext_2) bus.rdata_ext_2 <= dmem[bus.addr_ext_2[5:3]];
    end

    int dwr_cnt = 0;
    int iwr_cnt = 0;
    int ren_cnt = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (bus.wen_ext_2) dwr_cnt++;
        if (bus.wen_ext) iwr_cnt++;
        if (bus.ren_ext_2) ren_cnt++;
        if (bus.done) done_cnt++;
    end

    int n_pass = 0;
    int n_total = 0;
    load_vec_t lv [16];
    logic [63:0] dexp [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic run_load(input int base, input bit toggle);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_data  = lv[base+i].data;
            bus.in_valid = 1'b1;
            check("in_ready", bus.in_ready, 1);
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("wen_ext_2", bus.wen_ext_2, !lv[base+i].imem);
            check("wen_ext", bus.wen_ext, lv[base+i].imem);
            if (lv[base+i].imem) begin
                check("addr_ext", bus.addr_ext, lv[base+i].addr);
                check("wdata_ext", bus.wdata_ext, lv[base+i].data);
            end else begin
                check("addr_ext_2", bus.addr_ext_2, lv[base+i].addr);
                check("wdata_ext_2", bus.wdata_ext_2, lv[base+i].data);
            end
            if (toggle) begin
                @(negedge clk);
                check("idle_wen_ext_2", bus.wen_ext_2, 0);
                check("idle_wen_ext", bus.wen_ext, 0);
            end
        end
        if (!toggle) begin
            check("enable_release", bus.enable, 0);
            @(negedge clk);
        end
        check("enable_run", bus.enable, 1);
    endtask

    task automatic run_dump(input int len, input int stall, input int base);
        int r0;
        int d0;
        int w;
        r0 = ren_cnt;
        d0 = done_cnt;
        bus.dump_len  = CNT_W'(len);
        bus.dump_req  = 1'b1;
        bus.out_ready = (stall == 0);
        @(negedge clk);
        bus.dump_req = 1'b0;
        check("dump_ren_first", bus.ren_ext_2, 1);
        check("dump_addr_first", bus.addr_ext_2, 0);
        @(negedge clk);
        check("dump_valid_early", bus.out_valid, 0);
        @(negedge clk);
        check("dump_valid_latency", bus.out_valid, 1);
        for (int k = 0; k < len; k++) begin
            w = 0;
            while (!bus.out_valid && w < 10) begin
                @(negedge clk);
                w++;
            end
            check("dump_valid", bus.out_valid, 1);
            check("dump_data", bus.out_data, dexp[base+k]);
            if (k == 0 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_data", bus.out_data, dexp[base]);
                    check("stall_ren", bus.ren_ext_2, 0);
                end
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            check("dump_valid_drop", bus.out_valid, 0);
            if (k == len - 1) begin
                check("dump_done", bus.done, 1);
            end else begin
                check("dump_ren_next", bus.ren_ext_2, 1);
                check("dump_addr_next", bus.addr_ext_2, 64'(k + 1) << 3);
            end
        end
        @(negedge clk);
        check("done_pulse_width", bus.done, 0);
        check("done_count", done_cnt - d0, 1);
        check("ren_count", ren_cnt - r0, len);
        check("dump_enable", bus.enable, 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int d0;
        int i0;
        int r0;
        lv[0]  = '{64'h10, 1'b0, 64'd0};
        lv[1]  = '{64'h11, 1'b0, 64'd8};
        lv[2]  = '{64'h12, 1'b0, 64'd16};
        lv[3]  = '{64'h13, 1'b0, 64'd24};
        lv[4]  = '{64'h14, 1'b1, 64'd0};
        lv[5]  = '{64'h15, 1'b1, 64'd4};
        lv[6]  = '{64'h16, 1'b1, 64'd8};
        lv[7]  = '{64'h17, 1'b1, 64'd12};
        lv[8]  = '{64'h0A, 1'b0, 64'd0};
        lv[9]  = '{64'h0B, 1'b0, 64'd8};
        lv[10] = '{64'h0C, 1'b0, 64'd16};
        lv[11] = '{64'h0D, 1'b0, 64'd24};
        lv[12] = '{64'h20, 1'b1, 64'd0};
        lv[13] = '{64'h21, 1'b1, 64'd4};
        lv[14] = '{64'h22, 1'b1, 64'd8};
        lv[15] = '{64'h23, 1'b1, 64'd12};
        dexp = '{64'h10, 64'h11, 64'h12, 64'h0A, 64'h0B, 64'h0C};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.halt = 1'b0;
        bus.dump_req = 1'b0;
        bus.dump_len = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_enable", bus.enable, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_wen_ext", bus.wen_ext, 0);
        check("rst_wen_ext_2", bus.wen_ext_2, 0);
        check("rst_ren_ext", bus.ren_ext, 0);
        check("rst_ren_ext_2", bus.ren_ext_2, 0);
        check("rst_addr_ext_2", bus.addr_ext_2, 0);
        check("rst_out_data", bus.out_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);

        // Held-valid load, then start while running must be ignored.
        d0 = dwr_cnt;
        i0 = iwr_cnt;
        run_load(0, 1'b0);
        check("load_dmem_writes", dwr_cnt - d0, 4);
        check("load_imem_writes", iwr_cnt - i0, 4);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("run_start_enable", bus.enable, 1);
        check("run_start_in_ready", bus.in_ready, 0);
        @(negedge clk);
        check("run_start_busy", bus.busy, 1);
        check("run_start_writes", dwr_cnt - d0 + iwr_cnt - i0, 8);

        bus.halt = 1'b1;
        @(negedge clk);
        check("halt_enable", bus.enable, 0);
        check("halt_busy", bus.busy, 0);

        // Zero-length dump completes immediately with no read.
        d0 = done_cnt;
        r0 = ren_cnt;
        bus.dump_len = '0;
        bus.dump_req = 1'b1;
        @(negedge clk);
        bus.dump_req = 1'b0;
        check("len0_done", bus.done, 1);
        check("len0_ren", bus.ren_ext_2, 0);
        @(negedge clk);
        check("len0_done_drop", bus.done, 0);
        check("len0_done_count", done_cnt - d0, 1);
        check("len0_ren_count", ren_cnt - r0, 0);
        check("len0_busy", bus.busy, 0);

        run_dump(3, 5, 0);

        // Reset in the middle of a load, then reload with a gappy stream.
        bus.halt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 64'h55;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_wen_ext_2", bus.wen_ext_2, 0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midrst_idle_busy", bus.busy, 0);

        d0 = dwr_cnt;
        i0 = iwr_cnt;
        run_load(8, 1'b1);
        check("toggle_dmem_writes", dwr_cnt - d0, 4);
        check("toggle_imem_writes", iwr_cnt - i0, 4);

        // Halt and dump request together: only the halt takes effect.
        r0 = ren_cnt;
        bus.halt = 1'b1;
        bus.dump_len = CNT_W'(3);
        bus.dump_req = 1'b1;
        @(negedge clk);
        bus.dump_req = 1'b0;
        check("both_enable", bus.enable, 0);
        check("both_busy", bus.busy, 0);
        check("both_ren", bus.ren_ext_2, 0);
        repeat (3) @(negedge clk);
        check("both_out_valid", bus.out_valid, 0);
        check("both_ren_count", ren_cnt - r0, 0);

        run_dump(3, 0, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
